// File: rtl/m68k_bus_pkg.sv
// rtl/m68k_bus_pkg.sv - shared types and constants for the 68000 bus responder
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACK,
        ST_RELEASE,
        ST_WATCH,
        ST_BERR,
        ST_HOLD
    } state_t;

    localparam logic [2:0] FC_IACK = 3'b111;
    localparam logic [2:0] REG_ID  = 3'd4;

endpackage

// File: rtl/bus_sync2.sv
// rtl/bus_sync2.sv - two-flop synchroniser, resets to the bus idle level (all ones)
module bus_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/m68k_bus_responder.sv
// rtl/m68k_bus_responder.sv - 68000 bus slave: 16-byte register window, wait-state DTACK, BERR watchdog
module m68k_bus_responder
    import m68k_bus_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR   = 24'hFF0000,
    parameter int          WAIT_STATES = 2,
    parameter int          TIMEOUT     = 64,
    parameter logic [15:0] ID_VALUE    = 16'h68C0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AS,
    input  logic        UDS,
    input  logic        LDS,
    input  logic        RW,
    input  logic [2:0]  FC,
    input  logic [23:1] A,
    input  logic [15:0] D_IN,
    input  logic        DTACK_IN,
    output logic        DTACK_OUT,
    output logic        DTACK_OE,
    output logic        BERR_OUT,
    output logic        BERR_OE,
    output logic [15:0] D_OUT,
    output logic        D_OE
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    logic [4:0] sync_q;
    logic       as_s, uds_s, lds_s, rw_s, dtack_s;

    bus_sync2 #(.WIDTH(5)) u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   ({AS, UDS, LDS, RW, DTACK_IN}),
        .q   (sync_q)
    );

    assign {as_s, uds_s, lds_s, rw_s, dtack_s} = sync_q;

    state_t      state;
    logic [23:1] addr;
    logic [2:0]  fc;
    logic [3:0]  wcnt;
    logic [7:0]  tcnt;
    logic [15:0] regs [0:3];

    logic [2:0]  idx;
    logic        hit;
    logic        enter_ack;
    logic [15:0] read_word;

    assign idx = addr[3:1];
    assign hit = (addr[23:4] == BASE_ADDR[23:4]) && (fc != FC_IACK);

    // ACK is entered either straight from DECODE (no wait states) or from the last WAIT cycle
    always_comb begin
        enter_ack = 1'b0;
        if (!as_s) begin
            if (state == ST_DECODE && hit && WAIT_STATES == 0)
                enter_ack = 1'b1;
            else if (state == ST_WAIT && wcnt <= 4'd1)
                enter_ack = 1'b1;
        end
    end

    always_comb begin
        read_word = 16'h0000;
        if (!idx[2])
            read_word = regs[idx[1:0]];
        else if (idx == REG_ID)
            read_word = ID_VALUE;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            addr      <= '0;
            fc        <= '0;
            wcnt      <= '0;
            tcnt      <= '0;
            DTACK_OUT <= 1'b1;
            DTACK_OE  <= 1'b0;
            BERR_OUT  <= 1'b1;
            BERR_OE   <= 1'b0;
            D_OUT     <= '0;
            D_OE      <= 1'b0;
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!as_s) begin
                        addr  <= A;
                        fc    <= FC;
                        tcnt  <= 8'd1;
                        state <= ST_DECODE;
                    end else begin
                        tcnt <= 8'd0;
                    end
                end
                ST_DECODE: begin
                    if (tcnt != 8'hFF)
                        tcnt <= tcnt + 8'd1;
                    if (as_s)
                        state <= ST_IDLE;
                    else if (!hit)
                        state <= ST_WATCH;
                    else if (enter_ack)
                        state <= ST_ACK;
                    else begin
                        wcnt  <= WAIT_LOAD;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (as_s)
                        state <= ST_IDLE;
                    else if (enter_ack)
                        state <= ST_ACK;
                    else
                        wcnt <= wcnt - 4'd1;
                end
                ST_ACK: begin
                    if (as_s) begin
                        DTACK_OUT <= 1'b1;
                        D_OE      <= 1'b0;
                        state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    DTACK_OE <= 1'b0;
                    // a master that starts the next cycle immediately is picked up here
                    if (!as_s) begin
                        addr  <= A;
                        fc    <= FC;
                        tcnt  <= 8'd1;
                        state <= ST_DECODE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WATCH: begin
                    if (tcnt != 8'hFF)
                        tcnt <= tcnt + 8'd1;
                    if (as_s)
                        state <= ST_IDLE;
                    else if (!dtack_s)
                        state <= ST_HOLD;
                    else if (tcnt >= TO_LAST) begin
                        BERR_OUT <= 1'b0;
                        BERR_OE  <= 1'b1;
                        state    <= ST_BERR;
                    end
                end
                ST_BERR, ST_HOLD: begin
                    if (as_s) begin
                        BERR_OUT <= 1'b1;
                        BERR_OE  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (enter_ack) begin
                DTACK_OUT <= 1'b0;
                DTACK_OE  <= 1'b1;
                if (rw_s) begin
                    D_OUT <= read_word;
                    D_OE  <= 1'b1;
                end else if (!idx[2]) begin
                    if (!uds_s)
                        regs[idx[1:0]][15:8] <= D_IN[15:8];
                    if (!lds_s)
                        regs[idx[1:0]][7:0] <= D_IN[7:0];
                end
            end
        end
    end

endmodule
